// File: rtl/mac_tx.sv
// ---------------------------------------------------------------------------
// mac_tx : Ethernet MAC transmitter (GMII byte interface)
//
// Takes a typed payload stream from the IP/ARP layer and emits a complete
// Ethernet frame: 7x 0x55 + 0xD5 preamble/SFD, destination MAC, source MAC,
// EtherType, payload (optionally zero-padded to 46 bytes) and the CRC32 FCS,
// followed by an enforced inter-frame gap.
//
// Build option: define MAC_TX_PAD_EN to zero-pad short payloads to 46 bytes.
// Without it, the PAD state does not exist and short frames go out unpadded.
//
// Ports:
//   i_clk / i_rst                 byte clock, asynchronous active-high reset
//   i_src_mac[_valid]             load new source MAC
//   i_dest_mac[_valid]            load new destination MAC
//   i_pre_type                    EtherType, sampled at frame start
//   i_pre_data/valid/last         payload byte stream
//   o_pre_ready                   payload byte accepted on valid & ready
//   o_tx_busy                     high whenever the FSM is not idle
//   o_tx_abort                    one-cycle pulse on payload underrun
//   o_gmii_data / o_gmii_valid    registered GMII TXD / TX_EN
// ---------------------------------------------------------------------------

// Byte-wide Ethernet CRC32 (reflected polynomial 0xEDB88320, init all-ones).
// o_crc is the complemented register, i.e. the FCS value with [7:0] sent first.
module crc32_d8 (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clr,
    input  logic        i_en,
    input  logic [7:0]  i_data,
    output logic [31:0] o_crc
);
    logic [31:0] crc_reg;
    logic [31:0] crc_next;

    always_comb begin
        crc_next = crc_reg;
        for (int b = 0; b < 8; b++) begin
            if (crc_next[0] ^ i_data[b])
                crc_next = (crc_next >> 1) ^ 32'hEDB88320;
            else
                crc_next = crc_next >> 1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            crc_reg <= '1;
        else if (i_clr)
            crc_reg <= '1;
        else if (i_en)
            crc_reg <= crc_next;
    end

    assign o_crc = ~crc_reg;
endmodule

module mac_tx #(
    parameter logic [47:0] P_SRC_MAC    = 48'h0,
    parameter logic [47:0] P_DEST_MAC   = 48'h0,
    parameter int          P_IFG_CYCLES = 12
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [47:0] i_src_mac,
    input  logic        i_src_mac_valid,
    input  logic [47:0] i_dest_mac,
    input  logic        i_dest_mac_valid,
    input  logic [15:0] i_pre_type,
    input  logic [7:0]  i_pre_data,
    input  logic        i_pre_valid,
    input  logic        i_pre_last,
    output logic        o_pre_ready,
    output logic        o_tx_busy,
    output logic        o_tx_abort,
    output logic [7:0]  o_gmii_data,
    output logic        o_gmii_valid
);
    typedef enum logic [3:0] {
        S_IDLE, S_PREAMBLE, S_DEST, S_SRC, S_TYPE, S_PAYLOAD,
`ifdef MAC_TX_PAD_EN
        S_PAD,
`endif
        S_FCS, S_IFG
    } state_t;

`ifdef MAC_TX_PAD_EN
    localparam logic [15:0] MIN_PAYLOAD = 16'd46;
`endif
    // The IDLE cycle before the next preamble is itself one gap cycle, so the
    // IFG state only has to cover the remaining P_IFG_CYCLES-1 cycles.
    localparam bit          IFG_SKIP = (P_IFG_CYCLES <= 1);
    localparam logic [15:0] IFG_LAST = (P_IFG_CYCLES > 1) ? 16'(P_IFG_CYCLES - 2) : 16'd0;

    state_t      state_reg;
    logic [47:0] src_mac_reg, dest_mac_reg;
    logic [47:0] src_work_reg, dest_work_reg;
    logic [15:0] type_work_reg;
    logic [2:0]  idx_reg;
    logic [15:0] pay_cnt_reg, ifg_cnt_reg;
    logic [15:0] pay_cnt_next;
    logic [7:0]  byte_next;
    logic        crc_clr, crc_en;
    logic [31:0] crc;

    function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] i);
        case (i)
            3'd0:    mac_byte = mac[47:40];
            3'd1:    mac_byte = mac[39:32];
            3'd2:    mac_byte = mac[31:24];
            3'd3:    mac_byte = mac[23:16];
            3'd4:    mac_byte = mac[15:8];
            default: mac_byte = mac[7:0];
        endcase
    endfunction

    // Configured MACs; working copies are taken only at frame start.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            src_mac_reg  <= P_SRC_MAC;
            dest_mac_reg <= P_DEST_MAC;
        end else begin
            if (i_src_mac_valid)  src_mac_reg  <= i_src_mac;
            if (i_dest_mac_valid) dest_mac_reg <= i_dest_mac;
        end
    end

    assign o_pre_ready  = (state_reg == S_PAYLOAD);
    assign o_tx_busy    = (state_reg != S_IDLE);
    assign pay_cnt_next = (pay_cnt_reg == 16'hFFFF) ? pay_cnt_reg : pay_cnt_reg + 16'd1;
    assign crc_clr      = (state_reg == S_IDLE) || (state_reg == S_PREAMBLE);

    // Byte the output register loads on the next edge; the CRC sees the same
    // byte so the FCS covers exactly what went out from DEST through PAD.
    always_comb begin
        byte_next = 8'h00;
        crc_en    = 1'b0;
        case (state_reg)
            S_PREAMBLE: byte_next = (idx_reg == 3'd7) ? 8'hD5 : 8'h55;
            S_DEST:     begin byte_next = mac_byte(dest_work_reg, idx_reg); crc_en = 1'b1; end
            S_SRC:      begin byte_next = mac_byte(src_work_reg, idx_reg);  crc_en = 1'b1; end
            S_TYPE:     begin
                byte_next = idx_reg[0] ? type_work_reg[7:0] : type_work_reg[15:8];
                crc_en    = 1'b1;
            end
            S_PAYLOAD:  begin byte_next = i_pre_data; crc_en = i_pre_valid; end
`ifdef MAC_TX_PAD_EN
            S_PAD:      begin byte_next = 8'h00; crc_en = 1'b1; end
`endif
            S_FCS: begin
                case (idx_reg[1:0])
                    2'd0:    byte_next = crc[7:0];
                    2'd1:    byte_next = crc[15:8];
                    2'd2:    byte_next = crc[23:16];
                    default: byte_next = crc[31:24];
                endcase
            end
            default: ;
        endcase
    end

    crc32_d8 u_crc (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clr  (crc_clr),
        .i_en   (crc_en),
        .i_data (byte_next),
        .o_crc  (crc)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg     <= S_IDLE;
            o_gmii_data   <= 8'h00;
            o_gmii_valid  <= 1'b0;
            o_tx_abort    <= 1'b0;
            idx_reg       <= 3'd0;
            pay_cnt_reg   <= 16'd0;
            ifg_cnt_reg   <= 16'd0;
            src_work_reg  <= 48'h0;
            dest_work_reg <= 48'h0;
            type_work_reg <= 16'h0;
        end else begin
            o_tx_abort <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    o_gmii_valid <= 1'b0;
                    o_gmii_data  <= 8'h00;
                    if (i_pre_valid) begin
                        state_reg     <= S_PREAMBLE;
                        idx_reg       <= 3'd0;
                        pay_cnt_reg   <= 16'd0;
                        src_work_reg  <= src_mac_reg;
                        dest_work_reg <= dest_mac_reg;
                        type_work_reg <= i_pre_type;
                    end
                end
                S_PREAMBLE: begin
                    o_gmii_valid <= 1'b1;
                    o_gmii_data  <= byte_next;
                    idx_reg      <= idx_reg + 3'd1;
                    if (idx_reg == 3'd7) begin
                        state_reg <= S_DEST;
                        idx_reg   <= 3'd0;
                    end
                end
                S_DEST, S_SRC: begin
                    o_gmii_data <= byte_next;
                    idx_reg     <= idx_reg + 3'd1;
                    if (idx_reg == 3'd5) begin
                        state_reg <= (state_reg == S_DEST) ? S_SRC : S_TYPE;
                        idx_reg   <= 3'd0;
                    end
                end
                S_TYPE: begin
                    o_gmii_data <= byte_next;
                    idx_reg     <= idx_reg + 3'd1;
                    if (idx_reg == 3'd1) begin
                        state_reg <= S_PAYLOAD;
                        idx_reg   <= 3'd0;
                    end
                end
                S_PAYLOAD: begin
                    if (i_pre_valid) begin
                        o_gmii_data <= byte_next;
                        pay_cnt_reg <= pay_cnt_next;
                        if (i_pre_last) begin
                            idx_reg <= 3'd0;
`ifdef MAC_TX_PAD_EN
                            state_reg <= (pay_cnt_next < MIN_PAYLOAD) ? S_PAD : S_FCS;
`else
                            state_reg <= S_FCS;
`endif
                        end
                    end else begin
                        // Underrun: abandon the frame without an FCS.
                        o_gmii_valid <= 1'b0;
                        o_gmii_data  <= 8'h00;
                        o_tx_abort   <= 1'b1;
                        ifg_cnt_reg  <= 16'd0;
                        state_reg    <= IFG_SKIP ? S_IDLE : S_IFG;
                    end
                end
`ifdef MAC_TX_PAD_EN
                S_PAD: begin
                    o_gmii_data <= byte_next;
                    pay_cnt_reg <= pay_cnt_next;
                    if (pay_cnt_next >= MIN_PAYLOAD) begin
                        state_reg <= S_FCS;
                        idx_reg   <= 3'd0;
                    end
                end
`endif
                S_FCS: begin
                    o_gmii_data <= byte_next;
                    idx_reg     <= idx_reg + 3'd1;
                    if (idx_reg == 3'd3) begin
                        ifg_cnt_reg <= 16'd0;
                        state_reg   <= IFG_SKIP ? S_IDLE : S_IFG;
                    end
                end
                S_IFG: begin
                    o_gmii_valid <= 1'b0;
                    o_gmii_data  <= 8'h00;
                    ifg_cnt_reg  <= ifg_cnt_reg + 16'd1;
                    if (ifg_cnt_reg == IFG_LAST)
                        state_reg <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end
endmodule
